block_sync_ctrl: RTL and testbench
==================================

BLOCK_SYNC_CTRL -- requirements
Module: block_sync_ctrl

Interface
REQ-001 Parameter LOCK_CNT, default 64, consecutive valid headers needed to declare lock (legal 1..127).
REQ-002 Parameter WINDOW, default 64, headers per error-monitoring window while locked (legal 2..127).
REQ-003 Parameter BAD_LIMIT, default 16, invalid headers within one window that drop lock (legal 1..WINDOW).
REQ-004 Parameter SLIP_WAIT, default 8, clk_i cycles ignored after a slip while the seeker/gearbox pipeline settles (legal 1..255).
REQ-005 clk_i  input  1  system clock; all logic on rising edge.
REQ-006 rst_ni  input  1  synchronous, active-low reset.
REQ-007 en_i  input  1  enable; low forces HUNT and suppresses slips.
REQ-008 header_i  input  2  sync header of current 66b block from seeker/gearbox.
REQ-009 header_dv_i  input  1  header_i qualifier, at most one per block.
REQ-010 slip_o  output  1  one-cycle pulse requesting seeker to advance block offset by one bit.
REQ-011 block_lock_o  output  1  high while in LOCKED.
REQ-012 slip_cnt_o  output  8  saturating count of slips since reset.

Function
REQ-013 Valid header = 2'b01 (data) or 2'b10 (cmd); 2'b00 and 2'b11 are invalid.
REQ-014 FSM states: HUNT, LOCKED, SLIP_WAIT; header_i sampled only on cycles with header_dv_i=1.
REQ-015 HUNT: valid header -> good_cnt+1; good_cnt reaching LOCK_CNT -> LOCKED next cycle with good_cnt and bad_cnt cleared.
REQ-016 HUNT: invalid header -> slip_o=1 next cycle, good_cnt cleared, state -> SLIP_WAIT.
REQ-017 SLIP_WAIT: wait_cnt counts SLIP_WAIT clk_i cycles starting the cycle slip_o is high; header_dv_i ignored; then -> HUNT with counters cleared.
REQ-018 LOCKED: every header increments win_cnt; invalid header also increments bad_cnt.
REQ-019 LOCKED: bad_cnt reaching BAD_LIMIT -> slip_o pulse, block_lock_o low, state -> SLIP_WAIT, same cycle as REQ-016 timing.
REQ-020 LOCKED: win_cnt reaching WINDOW with bad_cnt < BAD_LIMIT -> win_cnt and bad_cnt cleared, stay LOCKED; if the WINDOW-th header is the BAD_LIMIT-th bad one, REQ-019 wins.
REQ-021 block_lock_o and slip_o are registered; slip_o never high on two consecutive cycles.
REQ-022 slip_cnt_o increments on each slip_o pulse, holds at 255.
REQ-023 en_i low: next cycle state HUNT, all counters except slip_cnt_o cleared, slip_o=0, block_lock_o=0; en_i low overrides a concurrent slip decision.
REQ-024 Counters 7-bit (good_cnt, win_cnt, bad_cnt), 8-bit wait_cnt; no wrap possible within legal parameter ranges.

Reset
REQ-025 rst_ni=0 at a clock edge: state HUNT, all counters 0, slip_o=0, block_lock_o=0, slip_cnt_o=0; reset mid-SLIP_WAIT or mid-LOCKED aborts immediately.
REQ-026 First header accepted on the first header_dv_i cycle after rst_ni returns high.

Structure
REQ-027 Shared package holds the FSM state enum and header constants (DATA_HEADER=2'b01, CMD_HEADER=2'b10), reused by the seeker.
REQ-028 Single flat module; no sub-module.

Verification
REQ-029 Reset, then 64 valid headers (dv every 8 cycles) -> block_lock_o rises the cycle after the 64th header; slip_o stays 0.
REQ-030 HUNT with 10 valid then 1 header 2'b11 -> one slip_o pulse, slip_cnt_o=1, next 8 cycles of dv ignored, good_cnt restarts at 0.
REQ-031 LOCKED, 15 invalid within a 64-header window -> lock held and counters clear at window end; 16 invalid -> lock drops, slip_o pulses once.
REQ-032 300 forced slips -> slip_cnt_o saturates at 255.
REQ-033 en_i driven low on the same cycle a slip would fire -> no slip_o, state HUNT, block_lock_o=0.
REQ-034 rst_ni low for one cycle during SLIP_WAIT -> all outputs 0 next cycle, HUNT resumes counting from 0.

Source files
------------

// File: rtl/block_sync_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// block_sync_ctrl_pkg : block-sync state encoding and 66b sync-header codes
// Rev 1.0
// ============================================================================
package block_sync_ctrl_pkg;

    localparam logic [1:0] DATA_HEADER = 2'b01;
    localparam logic [1:0] CMD_HEADER  = 2'b10;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_LOCKED    = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } sync_state_e;

    function automatic logic is_valid_header(input logic [1:0] hdr);
        return (hdr == DATA_HEADER) || (hdr == CMD_HEADER);
    endfunction

endpackage
`default_nettype wire

// File: rtl/block_sync_ctrl.sv
`default_nettype none
// ============================================================================
// block_sync_ctrl : 66b block-lock state machine driving seeker bit slips
// Rev 1.0
// ============================================================================
module block_sync_ctrl
    import block_sync_ctrl_pkg::*;
#(
    parameter int LOCK_CNT  = 64,
    parameter int WINDOW    = 64,
    parameter int BAD_LIMIT = 16,
    parameter int SLIP_WAIT = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] header_i,
    input  logic       header_dv_i,
    output logic       slip_o,
    output logic       block_lock_o,
    output logic [7:0] slip_cnt_o
);

    localparam logic [6:0] c_lock_cnt  = 7'(LOCK_CNT);
    localparam logic [6:0] c_window    = 7'(WINDOW);
    localparam logic [6:0] c_bad_limit = 7'(BAD_LIMIT);
    localparam logic [7:0] c_wait_last = 8'(SLIP_WAIT - 1);

    sync_state_e r_state, w_state_nxt;
    logic [6:0]  r_good_cnt, w_good_cnt_nxt;
    logic [6:0]  r_win_cnt,  w_win_cnt_nxt;
    logic [6:0]  r_bad_cnt,  w_bad_cnt_nxt;
    logic [7:0]  r_wait_cnt, w_wait_cnt_nxt;
    logic [7:0]  r_slip_cnt, w_slip_cnt_nxt;
    logic        r_slip,     w_slip_nxt;
    logic        r_lock,     w_lock_nxt;
    logic        w_valid;

    assign w_valid = is_valid_header(header_i);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_HUNT;
            r_good_cnt <= '0;
            r_win_cnt  <= '0;
            r_bad_cnt  <= '0;
            r_wait_cnt <= '0;
            r_slip_cnt <= '0;
            r_slip     <= 1'b0;
            r_lock     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_cnt_nxt;
            r_win_cnt  <= w_win_cnt_nxt;
            r_bad_cnt  <= w_bad_cnt_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_slip_cnt <= w_slip_cnt_nxt;
            r_slip     <= w_slip_nxt;
            r_lock     <= w_lock_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_win_cnt_nxt  = r_win_cnt;
        w_bad_cnt_nxt  = r_bad_cnt;
        w_wait_cnt_nxt = r_wait_cnt;
        w_slip_cnt_nxt = r_slip_cnt;
        w_slip_nxt     = 1'b0;
        w_lock_nxt     = r_lock;

        if (!en_i) begin
            w_state_nxt    = ST_HUNT;
            w_good_cnt_nxt = '0;
            w_win_cnt_nxt  = '0;
            w_bad_cnt_nxt  = '0;
            w_wait_cnt_nxt = '0;
            w_lock_nxt     = 1'b0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    w_lock_nxt = 1'b0;
                    if (header_dv_i) begin
                        if (!w_valid) begin
                            w_slip_nxt     = 1'b1;
                            w_good_cnt_nxt = '0;
                            w_wait_cnt_nxt = '0;
                            w_state_nxt    = ST_SLIP_WAIT;
                        end else if (r_good_cnt + 7'd1 == c_lock_cnt) begin
                            w_good_cnt_nxt = '0;
                            w_win_cnt_nxt  = '0;
                            w_bad_cnt_nxt  = '0;
                            w_lock_nxt     = 1'b1;
                            w_state_nxt    = ST_LOCKED;
                        end else begin
                            w_good_cnt_nxt = r_good_cnt + 7'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (header_dv_i) begin
                        // Losing lock takes priority over the window rollover.
                        if (!w_valid && (r_bad_cnt + 7'd1 == c_bad_limit)) begin
                            w_slip_nxt     = 1'b1;
                            w_lock_nxt     = 1'b0;
                            w_win_cnt_nxt  = '0;
                            w_bad_cnt_nxt  = '0;
                            w_wait_cnt_nxt = '0;
                            w_state_nxt    = ST_SLIP_WAIT;
                        end else if (r_win_cnt + 7'd1 == c_window) begin
                            w_win_cnt_nxt = '0;
                            w_bad_cnt_nxt = '0;
                        end else begin
                            w_win_cnt_nxt = r_win_cnt + 7'd1;
                            w_bad_cnt_nxt = r_bad_cnt + {6'd0, ~w_valid};
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    // Headers arriving here come from the pre-slip alignment.
                    if (r_wait_cnt == c_wait_last) begin
                        w_wait_cnt_nxt = '0;
                        w_good_cnt_nxt = '0;
                        w_win_cnt_nxt  = '0;
                        w_bad_cnt_nxt  = '0;
                        w_state_nxt    = ST_HUNT;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_lock_nxt  = 1'b0;
                end
            endcase
        end

        if (w_slip_nxt && (r_slip_cnt != 8'hFF)) begin
            w_slip_cnt_nxt = r_slip_cnt + 8'd1;
        end
    end

    assign slip_o       = r_slip;
    assign block_lock_o = r_lock;
    assign slip_cnt_o   = r_slip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_block_sync_ctrl.sv
`default_nettype none
// ============================================================================
// tb_block_sync_ctrl : randomized bench for block_sync_ctrl with header-level model
// Rev 1.0
// ============================================================================
module tb_block_sync_ctrl;

    localparam int LOCK_CNT  = 64;
    localparam int WINDOW    = 64;
    localparam int BAD_LIMIT = 16;
    localparam int SLIP_WAIT = 8;

    logic       clk_i       = 1'b0;
    logic       rst_ni      = 1'b0;
    logic       en_i        = 1'b0;
    logic [1:0] header_i    = 2'b00;
    logic       header_dv_i = 1'b0;
    logic       slip_o;
    logic       block_lock_o;
    logic [7:0] slip_cnt_o;

    block_sync_ctrl #(
        .LOCK_CNT (LOCK_CNT),
        .WINDOW   (WINDOW),
        .BAD_LIMIT(BAD_LIMIT),
        .SLIP_WAIT(SLIP_WAIT)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .header_i    (header_i),
        .header_dv_i (header_dv_i),
        .slip_o      (slip_o),
        .block_lock_o(block_lock_o),
        .slip_cnt_o  (slip_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Header-level model: lock flag, header tallies and a blind-until cycle index.
    int cyc = 0;
    bit m_lock = 1'b0;
    bit m_slip = 1'b0;
    int m_good = 0;
    int m_bad = 0;
    int m_hdrs = 0;
    int m_blind_end = 0;
    int m_slips = 0;
    bit bad_pos[WINDOW];

    task automatic model_edge(input bit r, input bit e, input bit dv, input logic [1:0] h);
        bit valid;
        bit do_slip;
        valid   = (h == 2'b01) || (h == 2'b10);
        do_slip = 1'b0;
        m_slip  = 1'b0;
        if (!r) begin
            m_lock = 0; m_good = 0; m_bad = 0; m_hdrs = 0; m_blind_end = 0; m_slips = 0;
        end else if (!e) begin
            m_lock = 0; m_good = 0; m_bad = 0; m_hdrs = 0; m_blind_end = 0;
        end else if (dv && cyc >= m_blind_end) begin
            if (!m_lock) begin
                if (valid) begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        m_lock = 1; m_good = 0; m_bad = 0; m_hdrs = 0;
                    end
                end else begin
                    do_slip = 1'b1;
                end
            end else begin
                m_hdrs++;
                if (!valid) m_bad++;
                if (m_bad == BAD_LIMIT) do_slip = 1'b1;
                else if (m_hdrs == WINDOW) begin
                    m_hdrs = 0; m_bad = 0;
                end
            end
        end
        if (do_slip) begin
            m_slip = 1; m_lock = 0; m_good = 0; m_bad = 0; m_hdrs = 0;
            m_blind_end = cyc + 1 + SLIP_WAIT;
            if (m_slips < 255) m_slips++;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit dv, input logic [1:0] h);
        rst_ni = r; en_i = e; header_dv_i = dv; header_i = h;
        @(posedge clk_i);
        model_edge(r, e, dv, h);
        cyc++;
        #1;
    endtask

    function automatic logic [1:0] rand_valid();
        return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] rand_invalid();
        return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
    endfunction

    task automatic pick_bad(input int n, input int span);
        int cnt;
        int idx;
        for (int i = 0; i < WINDOW; i++) bad_pos[i] = 1'b0;
        cnt = 0;
        while (cnt < n) begin
            idx = int'($urandom_range(0, span - 1));
            if (!bad_pos[idx]) begin
                bad_pos[idx] = 1'b1;
                cnt++;
            end
        end
    endtask

    task automatic acquire_lock();
        for (int i = 0; i < LOCK_CNT; i++) step(1, 1, 1, rand_valid());
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 2'b11);
            checks++;
            if (slip_o !== 1'b0 || block_lock_o !== 1'b0 || slip_cnt_o !== 8'd0) begin
                errors++;
                $display("FAIL reset slip=%b lock=%b cnt=%0d want 0/0/0", slip_o, block_lock_o, slip_cnt_o);
            end
        end
    endtask

    task automatic test_lock_acquire();
        step(0, 1, 0, 2'b00);
        for (int h = 1; h <= LOCK_CNT; h++) begin
            step(1, 1, 1, rand_valid());
            checks++;
            if (block_lock_o !== (h == LOCK_CNT) || slip_o !== 1'b0) begin
                errors++;
                $display("FAIL lock_acquire hdr=%0d lock=%b slip=%b want lock=%b slip=0", h, block_lock_o, slip_o, h == LOCK_CNT);
            end
            for (int g = 0; g < 7; g++) begin
                step(1, 1, 0, 2'b00);
                checks++;
                if (slip_o !== 1'b0 || block_lock_o !== (h == LOCK_CNT)) begin
                    errors++;
                    $display("FAIL lock_acquire_idle hdr=%0d lock=%b slip=%b", h, block_lock_o, slip_o);
                end
            end
        end
    endtask

    task automatic test_slip_hunt();
        step(0, 1, 0, 2'b00);
        for (int i = 0; i < 10; i++) step(1, 1, 1, rand_valid());
        step(1, 1, 1, 2'b11);
        checks++;
        if (slip_o !== 1'b1 || slip_cnt_o !== 8'd1 || block_lock_o !== 1'b0) begin
            errors++;
            $display("FAIL hunt_slip slip=%b cnt=%0d lock=%b want 1/1/0", slip_o, slip_cnt_o, block_lock_o);
        end
        for (int i = 0; i < SLIP_WAIT; i++) begin
            step(1, 1, 1, rand_invalid());
            checks++;
            if (slip_o !== 1'b0 || slip_cnt_o !== 8'd1) begin
                errors++;
                $display("FAIL hunt_blind cyc=%0d slip=%b cnt=%0d want 0/1", i, slip_o, slip_cnt_o);
            end
        end
        for (int h = 1; h <= LOCK_CNT; h++) begin
            step(1, 1, 1, rand_valid());
            checks++;
            if (block_lock_o !== (h == LOCK_CNT) || slip_o !== 1'b0) begin
                errors++;
                $display("FAIL hunt_restart hdr=%0d lock=%b slip=%b want lock=%b", h, block_lock_o, slip_o, h == LOCK_CNT);
            end
        end
    endtask

    task automatic test_window();
        step(0, 1, 0, 2'b00);
        acquire_lock();
        for (int w = 0; w < 2; w++) begin
            pick_bad(BAD_LIMIT - 1, WINDOW);
            for (int i = 0; i < WINDOW; i++) begin
                step(1, 1, 1, bad_pos[i] ? rand_invalid() : rand_valid());
                checks++;
                if (block_lock_o !== 1'b1 || slip_o !== 1'b0) begin
                    errors++;
                    $display("FAIL window_hold win=%0d hdr=%0d lock=%b slip=%b want 1/0", w, i, block_lock_o, slip_o);
                end
            end
        end
        // The last header of the window is also the BAD_LIMIT-th bad one.
        pick_bad(BAD_LIMIT - 1, WINDOW - 1);
        bad_pos[WINDOW - 1] = 1'b1;
        for (int i = 0; i < WINDOW; i++) begin
            step(1, 1, 1, bad_pos[i] ? rand_invalid() : rand_valid());
            checks++;
            if (block_lock_o !== (i != WINDOW - 1) || slip_o !== (i == WINDOW - 1)) begin
                errors++;
                $display("FAIL window_edge hdr=%0d lock=%b slip=%b want %b/%b", i, block_lock_o, slip_o, i != WINDOW - 1, i == WINDOW - 1);
            end
        end
        for (int i = 0; i < SLIP_WAIT; i++) begin
            step(1, 1, 0, 2'b00);
            checks++;
            if (slip_o !== 1'b0 || block_lock_o !== 1'b0) begin
                errors++;
                $display("FAIL window_after_drop cyc=%0d slip=%b lock=%b want 0/0", i, slip_o, block_lock_o);
            end
        end
        acquire_lock();
        pick_bad(BAD_LIMIT, WINDOW);
        for (int i = 0; i < WINDOW; i++) begin
            step(1, 1, 1, bad_pos[i] ? rand_invalid() : rand_valid());
            checks++;
            if (block_lock_o !== m_lock || slip_o !== m_slip) begin
                errors++;
                $display("FAIL window_drop hdr=%0d lock=%b slip=%b want %b/%b", i, block_lock_o, slip_o, m_lock, m_slip);
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        step(0, 1, 0, 2'b00);
        for (int k = 1; k <= 300; k++) begin
            step(1, 1, 1, 2'b00);
            want = (k > 255) ? 255 : k;
            checks++;
            if (slip_o !== 1'b1 || slip_cnt_o !== 8'(want)) begin
                errors++;
                $display("FAIL slip_sat k=%0d slip=%b cnt=%0d want 1/%0d", k, slip_o, slip_cnt_o, want);
            end
            for (int i = 0; i < SLIP_WAIT; i++) step(1, 1, 0, 2'b00);
        end
    endtask

    task automatic test_en_override();
        step(0, 1, 0, 2'b00);
        for (int i = 0; i < 10; i++) step(1, 1, 1, rand_valid());
        step(1, 0, 1, 2'b11);
        checks++;
        if (slip_o !== 1'b0 || block_lock_o !== 1'b0 || slip_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL en_hunt slip=%b lock=%b cnt=%0d want 0/0/0", slip_o, block_lock_o, slip_cnt_o);
        end
        acquire_lock();
        for (int i = 0; i < BAD_LIMIT - 1; i++) step(1, 1, 1, rand_invalid());
        checks++;
        if (block_lock_o !== 1'b1) begin
            errors++;
            $display("FAIL en_pre_lock lock=%b want 1", block_lock_o);
        end
        step(1, 0, 1, 2'b00);
        checks++;
        if (slip_o !== 1'b0 || block_lock_o !== 1'b0 || slip_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL en_locked slip=%b lock=%b cnt=%0d want 0/0/0", slip_o, block_lock_o, slip_cnt_o);
        end
        for (int h = 1; h <= LOCK_CNT; h++) begin
            step(1, 1, 1, rand_valid());
            checks++;
            if (block_lock_o !== (h == LOCK_CNT) || slip_o !== 1'b0) begin
                errors++;
                $display("FAIL en_relock hdr=%0d lock=%b slip=%b want lock=%b", h, block_lock_o, slip_o, h == LOCK_CNT);
            end
        end
    endtask

    task automatic test_reset_in_slip_wait();
        step(0, 1, 0, 2'b00);
        for (int i = 0; i < 5; i++) step(1, 1, 1, rand_valid());
        step(1, 1, 1, 2'b00);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 2'b00);
        step(0, 1, 1, 2'b11);
        checks++;
        if (slip_o !== 1'b0 || block_lock_o !== 1'b0 || slip_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL rst_slipwait slip=%b lock=%b cnt=%0d want 0/0/0", slip_o, block_lock_o, slip_cnt_o);
        end
        for (int h = 1; h <= LOCK_CNT; h++) begin
            step(1, 1, 1, rand_valid());
            checks++;
            if (block_lock_o !== (h == LOCK_CNT) || slip_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_resume hdr=%0d lock=%b slip=%b want lock=%b", h, block_lock_o, slip_o, h == LOCK_CNT);
            end
        end
    endtask

    task automatic test_random();
        int len;
        int err_pct;
        int dv_pct;
        bit e;
        bit dv;
        step(0, 1, 0, 2'b00);
        for (int s = 0; s < 40; s++) begin
            len = int'($urandom_range(50, 200));
            case ($urandom_range(0, 2))
                0: err_pct = 0;
                1: err_pct = 2;
                default: err_pct = 30;
            endcase
            dv_pct = int'($urandom_range(30, 100));
            for (int i = 0; i < len; i++) begin
                e  = ($urandom_range(0, 99) != 0);
                dv = (int'($urandom_range(0, 99)) < dv_pct);
                step(1, e, dv, (int'($urandom_range(0, 99)) < err_pct) ? rand_invalid() : rand_valid());
                checks++;
                if (slip_o !== m_slip) begin
                    errors++;
                    $display("FAIL rand_slip cyc=%0d got %b want %b", cyc, slip_o, m_slip);
                end
                checks++;
                if (block_lock_o !== m_lock) begin
                    errors++;
                    $display("FAIL rand_lock cyc=%0d got %b want %b", cyc, block_lock_o, m_lock);
                end
                checks++;
                if (slip_cnt_o !== 8'(m_slips)) begin
                    errors++;
                    $display("FAIL rand_slip_cnt cyc=%0d got %0d want %0d", cyc, slip_cnt_o, m_slips);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_slip_hunt();
        test_window();
        test_saturation();
        test_en_override();
        test_reset_in_slip_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
